// File: rtl/cam_way_sched_if.sv
// Request, command and response bundle between the session CAM scheduler and its environment.
// The slave modport is the scheduler's view. The master modport is the requester/way/consumer side.
interface cam_way_sched_if #(
    parameter int K_W = 32,
    parameter int V_W = 16
);
    logic           ins_req_valid;
    logic           ins_req_ready;
    logic [K_W-1:0] ins_req_key;
    logic [V_W-1:0] ins_req_val;

    logic           del_req_valid;
    logic           del_req_ready;
    logic [1:0]     del_req_way;
    logic [K_W-1:0] del_req_key;

    logic [2:0]     way_full;

    logic [2:0]     cmd_valid;
    logic           cmd_op;
    logic [K_W-1:0] cmd_key;
    logic [V_W-1:0] cmd_val;
    logic [2:0]     cmd_ack;
    logic           cmd_ok;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_op;
    logic [1:0]     rsp_way;
    logic           rsp_ok;

    modport slave (
        input  ins_req_valid, ins_req_key, ins_req_val,
        input  del_req_valid, del_req_way, del_req_key,
        input  way_full, cmd_ack, cmd_ok, rsp_ready,
        output ins_req_ready, del_req_ready,
        output cmd_valid, cmd_op, cmd_key, cmd_val,
        output rsp_valid, rsp_op, rsp_way, rsp_ok
    );

    modport master (
        output ins_req_valid, ins_req_key, ins_req_val,
        output del_req_valid, del_req_way, del_req_key,
        output way_full, cmd_ack, cmd_ok, rsp_ready,
        input  ins_req_ready, del_req_ready,
        input  cmd_valid, cmd_op, cmd_key, cmd_val,
        input  rsp_valid, rsp_op, rsp_way, rsp_ok
    );
endinterface

// File: rtl/cam_way_sched.sv
// Insert/delete scheduler for the 3-way session CAM. It serialises one op at a time to a single way.
// It waits for that way's ack (with timeout) and returns a response.
module cam_way_sched #(
    parameter int K_W = 32,
    parameter int V_W = 16,
    parameter int TMO = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     rnd_mod,
    cam_way_sched_if.slave bus
);
    localparam int CNT_W = (TMO > 2) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t         state;
    logic [2:0]     cmd_valid_q;
    logic           op_q;
    logic [K_W-1:0] key_q;
    logic [V_W-1:0] val_q;
    logic           rsp_valid_q;
    logic [1:0]     way_q;
    logic           ok_q;
    logic           prio_del_q;
    logic [CNT_W-1:0] cnt_q;

    logic       grant_del;
    logic       grant_ins;
    logic       idle;
    logic [1:0] rnd_way;
    logic [1:0] rnd_nxt;
    logic [1:0] rnd_prv;
    logic [1:0] ins_way;
    logic       ins_full;
    logic [1:0] acc_way;
    logic       acc_reject;
    logic       ack_hit;

    // Delete wins unless an insert is also pending and the insert holds the priority.
    assign grant_del = bus.del_req_valid & (~bus.ins_req_valid | prio_del_q);
    assign grant_ins = bus.ins_req_valid & ~grant_del;
    assign idle      = rst_n & (state == S_IDLE);

    assign bus.del_req_ready = idle & grant_del;
    assign bus.ins_req_ready = idle & grant_ins;

    assign rnd_way = (rnd_mod == 2'd3) ? 2'd0 : rnd_mod;
    assign rnd_nxt = (rnd_way == 2'd2) ? 2'd0 : rnd_way + 2'd1;
    assign rnd_prv = (rnd_way == 2'd0) ? 2'd2 : rnd_way - 2'd1;

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        ins_way  = rnd_way;
        ins_full = 1'b0;
        if (!bus.way_full[rnd_way])      ins_way = rnd_way;
        else if (!bus.way_full[rnd_nxt]) ins_way = rnd_nxt;
        else if (!bus.way_full[rnd_prv]) ins_way = rnd_prv;
        else                             ins_full = 1'b1;
    end

    assign acc_way    = grant_del ? bus.del_req_way : ins_way;
    assign acc_reject = grant_del ? (bus.del_req_way == 2'd3) : ins_full;
    assign ack_hit    = |(bus.cmd_ack & cmd_valid_q);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cmd_valid_q <= '0;
            op_q        <= 1'b0;
            key_q       <= '0;
            val_q       <= '0;
            rsp_valid_q <= 1'b0;
            way_q       <= '0;
            ok_q        <= 1'b0;
            prio_del_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_del | grant_ins) begin
                        if (bus.ins_req_valid & bus.del_req_valid) prio_del_q <= grant_ins;
                        op_q  <= grant_del;
                        key_q <= grant_del ? bus.del_req_key : bus.ins_req_key;
                        val_q <= grant_del ? '0 : bus.ins_req_val;
                        way_q <= acc_way;
                        if (acc_reject) begin
                            ok_q        <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state       <= S_RESP;
                        end else begin
                            cmd_valid_q <= 3'b001 << acc_way;
                            cnt_q       <= '0;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // A matching ack on the last timeout cycle still reports the way's status.
                    if (ack_hit) begin
                        cmd_valid_q <= '0;
                        ok_q        <= bus.cmd_ok;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else if (cnt_q == CNT_W'(TMO - 1)) begin
                        cmd_valid_q <= '0;
                        ok_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_op    = op_q;
    assign bus.cmd_key   = key_q;
    assign bus.cmd_val   = val_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_op    = op_q;
    assign bus.rsp_way   = way_q;
    assign bus.rsp_ok    = ok_q;
endmodule
